delay_tap_sequencer: RTL and testbench
======================================

Name: delay_tap_sequencer

Overview:
- Parametrised controller that loads per-channel tap values into N IDELAYE3/ODELAYE3 primitives configured DELAY_TYPE="VAR_LOAD", one channel at a time.
- Tap values arrive on a serial scan chain; a strobe commits them. The block waits for IDELAYCTRL RDY, runs the EN_VTC-off / LOAD / settle / readback / EN_VTC-on sequence per channel, and returns readback values and error flags on a serial output chain.
- Sits between the top-level shift-register harness and the delay-line ROI.

Parameters:
- CHANNELS, 8, number of delay primitives driven (1..64).
- CNT_W, 9, tap count width (CNTVALUEIN/CNTVALUEOUT).
- VTC_WAIT, 8, cycles EN_VTC is held low before LOAD (>=1).
- SETTLE_CYCLES, 16, cycles after LOAD before CNTVALUEOUT is sampled (>=1).
- RDY_TIMEOUT, 1024, cycles to wait for rdy before flagging a timeout.

Ports:
- clk  in  1  single clock; also used as IDELAYCTRL REFCLK.
- rst_n  in  1  asynchronous, active-low reset.
- di  in  1  serial tap-value input; shifted in every cycle.
- stb  in  1  commit strobe; accepted only in IDLE.
- do  out  1  serial readback output: MSB of the readback shift register.
- rdy  in  1  IDELAYCTRL RDY.
- cntvaluein  out  CHANNELS*CNT_W  per-channel tap value; channel k at [k*CNT_W +: CNT_W].
- load  out  CHANNELS  per-channel LOAD pulse.
- en_vtc  out  CHANNELS  per-channel EN_VTC.
- cntvalueout  in  CHANNELS*CNT_W  per-channel readback; same packing as cntvaluein.
- busy  out  1  high while a sequence runs.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  CHANNELS+1  bit k = channel k readback mismatch; bit CHANNELS = rdy timeout; sticky until next accepted stb.

Behaviour:
- Reset values: do=0, cntvaluein=0, load=0, en_vtc=all 1, busy=0, done=0, err=0. State is IDLE; all shift and target registers are 0.
- Input chain: sin_shr (CHANNELS*CNT_W bits) shifts every cycle in every state: sin_shr <= {sin_shr[MSB-1:0], di}.
- Commit: stb in IDLE latches target <= sin_shr, clears err, and moves to WAIT_RDY. busy rises the next cycle. stb outside IDLE is ignored.
- WAIT_RDY:
  - rdy high -> VTC_OFF with ch=0.
  - Timeout counter reaching RDY_TIMEOUT-1 -> set err[CHANNELS], pulse done, return to IDLE; no load issued.
- VTC_OFF:
  - en_vtc[ch]=0; cntvaluein[ch] driven from target.
  - Wait VTC_WAIT cycles, then -> LOAD.
- LOAD: load[ch]=1 for exactly one cycle -> SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles -> CHECK.
- CHECK (1 cycle):
  - Capture cntvalueout[ch] into rb[ch].
  - If rb[ch] != target[ch], set err[ch].
  - -> VTC_ON.
- VTC_ON:
  - en_vtc[ch]=1 in this cycle.
  - ch == CHANNELS-1 -> DONE; else ch+1 -> VTC_OFF.
- DONE (1 cycle):
  - done=1.
  - Load the readback chain sout_shr <= {rb, err}, (CHANNELS*CNT_W + CHANNELS+1 bits).
  - -> IDLE; busy=0 from the next cycle.
- Output chain: sout_shr shifts left by one each cycle in IDLE only, filling with 0. do = sout_shr MSB, so the first bit out is rb[CHANNELS-1] MSB.
- Only one channel has en_vtc low at any time; load is one-hot or zero.
- cntvaluein holds target for all channels from commit onward; it changes only on the next accepted stb.
- rdy dropping mid-sequence:
  - Abort: restore en_vtc[ch]=1, set err[CHANNELS], pulse done, return to IDLE.
  - Channels already loaded keep their values.
- rst_n asserted mid-sequence: all outputs return to reset values immediately (asynchronous). en_vtc therefore returns to 1 without waiting.
- Counters are width ceil(log2(max param)) and saturate-free; they are reloaded at each state entry.

Test Plan:
- CHANNELS=4, rdy=1, shift in taps {0x010,0x020,0x1FF,0x000}, model echoes cntvaluein after LOAD, stb -> load pulses on ch0..3 in order, each exactly 1 cycle; en_vtc low for VTC_WAIT+1+SETTLE_CYCLES+1 cycles per channel; done once; err=0; do stream reproduces taps then 5 zero bits.
- Same setup, model returns 0x021 for ch1 -> err=5'b00010; readback of ch1 on do = 0x021.
- rdy held 0 -> after RDY_TIMEOUT cycles done pulses, err[4]=1, load never asserted, en_vtc stays 4'b1111.
- rdy dropped during SETTLE of ch2 -> en_vtc back to 1111 next cycle, err[4]=1, ch3 never loaded, done pulses.
- stb re-pulsed while busy -> ignored; target is unchanged and the sequence completes normally. A new stb after done restarts the sequence and clears err.
- rst_n asserted during LOAD of ch1 -> load=0 and en_vtc=1111 without a clock edge; busy=0; state is IDLE after release.

Source files
------------

// File: rtl/delay_tap_sequencer.sv
// Per-channel VAR_LOAD sequencer for IDELAYE3/ODELAYE3: scan-in taps, load one channel at a time, scan out readback.
// The serial output is named sdo because "do" is a reserved word in SystemVerilog.
module delay_tap_sequencer #(
  parameter int CHANNELS      = 8,
  parameter int CNT_W         = 9,
  parameter int VTC_WAIT      = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int RDY_TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      di,
  input  logic                      stb,
  output logic                      sdo,
  input  logic                      rdy,
  output logic [CHANNELS*CNT_W-1:0] cntvaluein,
  output logic [CHANNELS-1:0]       load,
  output logic [CHANNELS-1:0]       en_vtc,
  input  logic [CHANNELS*CNT_W-1:0] cntvalueout,
  output logic                      busy,
  output logic                      done,
  output logic [CHANNELS:0]         err
);

  localparam int SW    = CHANNELS * CNT_W;
  localparam int OW    = SW + CHANNELS + 1;
  localparam int MAXA  = (VTC_WAIT > SETTLE_CYCLES) ? VTC_WAIT : SETTLE_CYCLES;
  localparam int MAXP  = (MAXA > RDY_TIMEOUT) ? MAXA : RDY_TIMEOUT;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CW-1:0]  VTC_LAST    = CW'(VTC_WAIT - 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  RDY_LAST    = CW'(RDY_TIMEOUT - 1);
  localparam logic [CHW-1:0] CH_LAST     = CHW'(CHANNELS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_VTC_OFF  = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_SETTLE   = 3'd4;
  localparam logic [2:0] S_CHECK    = 3'd5;
  localparam logic [2:0] S_VTC_ON   = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]          state;
  logic [CHW-1:0]      ch;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       sin_shr;
  logic [SW-1:0]       target;
  logic [SW-1:0]       rb;
  logic [OW-1:0]       sout_shr;
  logic [CHANNELS-1:0] err_ch;
  logic                err_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ch       <= '0;
      cnt      <= '0;
      sin_shr  <= '0;
      target   <= '0;
      rb       <= '0;
      sout_shr <= '0;
      err_ch   <= '0;
      err_rdy  <= 1'b0;
    end else begin
      sin_shr <= {sin_shr[SW-2:0], di};
      if (state == S_IDLE) sout_shr <= {sout_shr[OW-2:0], 1'b0};

      case (state)
        S_IDLE: begin
          if (stb) begin
            target  <= sin_shr;
            err_ch  <= '0;
            err_rdy <= 1'b0;
            cnt     <= '0;
            state   <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (rdy) begin
            ch    <= '0;
            cnt   <= '0;
            state <= S_VTC_OFF;
          end else if (cnt == RDY_LAST) begin
            err_rdy <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          sout_shr <= {rb, err_rdy, err_ch};
          state    <= S_IDLE;
        end
        default: begin
          // Losing rdy anywhere in the per-channel sequence aborts through DONE,
          // which releases en_vtc and reports the partial result.
          if (!rdy) begin
            err_rdy <= 1'b1;
            state   <= S_DONE;
          end else begin
            case (state)
              S_VTC_OFF: begin
                if (cnt == VTC_LAST) begin
                  cnt   <= '0;
                  state <= S_LOAD;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              S_LOAD: begin
                cnt   <= '0;
                state <= S_SETTLE;
              end
              S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                  cnt   <= '0;
                  state <= S_CHECK;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              S_CHECK: begin
                rb[ch*CNT_W +: CNT_W] <= cntvalueout[ch*CNT_W +: CNT_W];
                if (cntvalueout[ch*CNT_W +: CNT_W] != target[ch*CNT_W +: CNT_W])
                  err_ch[ch] <= 1'b1;
                state <= S_VTC_ON;
              end
              S_VTC_ON: begin
                cnt <= '0;
                if (ch == CH_LAST) begin
                  state <= S_DONE;
                end else begin
                  ch    <= ch + 1'b1;
                  state <= S_VTC_OFF;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Decoded from state so an asynchronous reset releases en_vtc and load at once.
  always_comb begin
    en_vtc = '1;
    load   = '0;
    if (state == S_VTC_OFF || state == S_LOAD || state == S_SETTLE || state == S_CHECK)
      en_vtc[ch] = 1'b0;
    if (state == S_LOAD)
      load[ch] = 1'b1;
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign sdo        = sout_shr[OW-1];
  assign cntvaluein = target;
  assign err        = {err_rdy, err_ch};

endmodule

// File: tb/tb_delay_tap_sequencer.sv
// Directed/randomized bench for delay_tap_sequencer with a delay-line echo model and a
// behavioural reference for readback, error flags, load order and sequence timing.
module tb_delay_tap_sequencer;

  localparam int CH     = 4;
  localparam int CNTW   = 9;
  localparam int VW     = 3;
  localparam int SC     = 5;
  localparam int RT     = 40;
  localparam int SW     = CH * CNTW;
  localparam int OW     = SW + CH + 1;
  localparam int BUDGET = 400;
  localparam int PERCH  = VW + 1 + SC + 1;

  logic          clk = 1'b0;
  logic          rst_n, di, stb, sdo, rdy, busy, done;
  logic [SW-1:0] cntvaluein, cntvalueout;
  logic [CH-1:0] load, en_vtc;
  logic [CH:0]   err;

  delay_tap_sequencer #(
    .CHANNELS(CH), .CNT_W(CNTW), .VTC_WAIT(VW), .SETTLE_CYCLES(SC), .RDY_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .di(di), .stb(stb), .sdo(sdo), .rdy(rdy),
    .cntvaluein(cntvaluein), .load(load), .en_vtc(en_vtc), .cntvalueout(cntvalueout),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Delay-line model: CNTVALUEOUT follows CNTVALUEIN on LOAD unless overridden.
  logic [CNTW-1:0] echo    [CH];
  logic [CNTW-1:0] ovr_val [CH];
  logic [CH-1:0]   ovr_en;

  initial for (int k = 0; k < CH; k++) echo[k] = '0;

  always @(posedge clk)
    for (int k = 0; k < CH; k++)
      if (load[k]) echo[k] <= ovr_en[k] ? ovr_val[k] : cntvaluein[k*CNTW +: CNTW];

  always_comb begin
    cntvalueout = '0;
    for (int k = 0; k < CH; k++) cntvalueout[k*CNTW +: CNTW] = echo[k];
  end

  // Activity monitor
  logic [CH-1:0] load_log[$];
  int            low_cnt [CH];
  int            done_cnt;
  int            multi_viol = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (load != '0) load_log.push_back(load);
      if (done === 1'b1) done_cnt++;
      for (int k = 0; k < CH; k++) if (en_vtc[k] === 1'b0) low_cnt[k]++;
      if ($countones(~en_vtc) > 1 || $countones(load) > 1) multi_viol++;
    end
  end

  // Reference model state
  logic [CNTW-1:0] model_rb [CH];
  logic [CH:0]     exp_err;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_stream();
    logic [63:0] s;
    s = '0;
    for (int k = CH - 1; k >= 0; k--) s = (s << CNTW) | 64'(model_rb[k]);
    s = (s << (CH + 1)) | 64'(exp_err);
    return s;
  endfunction

  function automatic logic [63:0] load_pack();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < load_log.size() && i < 8; i++) v |= 64'(load_log[i]) << (4 * i);
    return v;
  endfunction

  function automatic logic [63:0] low_pack();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < CH; k++) v |= 64'(low_cnt[k] & 255) << (8 * k);
    return v;
  endfunction

  function automatic logic [63:0] low_exp(input int c3, input int c2, input int c1, input int c0);
    return {32'd0, 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [SW-1:0] rand_taps();
    logic [SW-1:0] t;
    for (int k = 0; k < CH; k++) t[k*CNTW +: CNTW] = CNTW'($urandom_range(0, 511));
    return t;
  endfunction

  // Channels below nchk completed CHECK; the rest keep their old readback.
  task automatic model_finish(input logic [SW-1:0] taps, input int nchk, input bit rdy_fail);
    exp_err = '0;
    for (int k = 0; k < nchk; k++) begin
      model_rb[k] = ovr_en[k] ? ovr_val[k] : taps[k*CNTW +: CNTW];
      exp_err[k]  = (model_rb[k] != taps[k*CNTW +: CNTW]);
    end
    exp_err[CH] = rdy_fail;
  endtask

  task automatic clear_logs();
    load_log.delete();
    for (int k = 0; k < CH; k++) low_cnt[k] = 0;
    done_cnt = 0;
  endtask

  task automatic shift_taps(input logic [SW-1:0] v);
    for (int i = SW - 1; i >= 0; i--) begin
      di = v[i];
      @(negedge clk);
    end
    di = 1'b0;
  endtask

  task automatic pulse_stb();
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_load(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (load[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("load_seen", 64'(ok), 64'd1);
  endtask

  task automatic collect_stream(output logic [63:0] s);
    s = '0;
    for (int i = 0; i < OW; i++) begin
      @(negedge clk);
      s = (s << 1) | 64'(sdo);
    end
  endtask

  task automatic full_run(input logic [SW-1:0] taps);
    int          cyc;
    logic [63:0] s;
    clear_logs();
    shift_taps(taps);
    pulse_stb();
    chk("busy_rise", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("seq_cycles", 64'(cyc), 64'(1 + CH * (VW + SC + 3)));
    collect_stream(s);
    model_finish(taps, CH, 1'b0);
    chk("err", 64'(err), 64'(exp_err));
    chk("stream", s, exp_stream());
    chk("load_count", 64'(load_log.size()), 64'd4);
    chk("load_order", load_pack(), 64'h8421);
    chk("vtc_low", low_pack(), low_exp(PERCH, PERCH, PERCH, PERCH));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("cntvaluein", 64'(cntvaluein), 64'(taps));
  endtask

  initial begin
    logic [SW-1:0] t, y;
    logic [63:0]   s;
    int            cyc;

    rst_n  = 1'b0;
    di     = 1'b0;
    stb    = 1'b0;
    rdy    = 1'b1;
    ovr_en = '0;
    for (int k = 0; k < CH; k++) begin
      ovr_val[k]  = '0;
      model_rb[k] = '0;
    end
    exp_err = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    chk("rst_sdo", 64'(sdo), 64'd0);
    chk("rst_cntvaluein", 64'(cntvaluein), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_en_vtc", 64'(en_vtc), 64'hF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal taps from the bring-up set
    t = {9'h000, 9'h1FF, 9'h020, 9'h010};
    full_run(t);

    // Channel 1 readback disagrees
    t = rand_taps();
    if (t[CNTW +: CNTW] == 9'h021) t[CNTW] = ~t[CNTW];
    ovr_en     = 4'b0010;
    ovr_val[1] = 9'h021;
    full_run(t);
    ovr_en = '0;

    // rdy never arrives
    clear_logs();
    rdy = 1'b0;
    t = rand_taps();
    shift_taps(t);
    pulse_stb();
    wait_done(cyc);
    chk("timeout_cycles", 64'(cyc), 64'(RT));
    collect_stream(s);
    model_finish(t, 0, 1'b1);
    chk("timeout_err", 64'(err), 64'(exp_err));
    chk("timeout_stream", s, exp_stream());
    chk("timeout_load_count", 64'(load_log.size()), 64'd0);
    chk("timeout_vtc_low", low_pack(), 64'd0);
    chk("timeout_done_count", 64'(done_cnt), 64'd1);
    rdy = 1'b1;

    // rdy lost during SETTLE of channel 2
    clear_logs();
    t = rand_taps();
    shift_taps(t);
    pulse_stb();
    wait_load(2);
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    chk("abort_en_vtc", 64'(en_vtc), 64'hF);
    chk("abort_done", 64'(done), 64'd1);
    rdy = 1'b1;
    collect_stream(s);
    model_finish(t, 2, 1'b1);
    chk("abort_err", 64'(err), 64'(exp_err));
    chk("abort_stream", s, exp_stream());
    chk("abort_load_count", 64'(load_log.size()), 64'd3);
    chk("abort_load_order", load_pack(), 64'h0421);
    chk("abort_vtc_low", low_pack(), low_exp(0, VW + 3, PERCH, PERCH));
    chk("abort_done_count", 64'(done_cnt), 64'd1);

    // New commit clears err; a strobe while busy is ignored
    clear_logs();
    t = rand_taps();
    shift_taps(t);
    pulse_stb();
    chk("restart_err_clear", 64'(err), 64'd0);
    y = t ^ SW'(36'h1_2345_6789);
    shift_taps(y);
    pulse_stb();
    wait_done(cyc);
    collect_stream(s);
    model_finish(t, CH, 1'b0);
    chk("restb_err", 64'(err), 64'(exp_err));
    chk("restb_stream", s, exp_stream());
    chk("restb_load_count", 64'(load_log.size()), 64'd4);
    chk("restb_cntvaluein", 64'(cntvaluein), 64'(t));
    chk("restb_done_count", 64'(done_cnt), 64'd1);

    // Random taps with random readback corruption
    for (int r = 0; r < 3; r++) begin
      t      = rand_taps();
      ovr_en = CH'($urandom_range(0, 15));
      for (int k = 0; k < CH; k++) ovr_val[k] = CNTW'($urandom_range(0, 511));
      full_run(t);
    end
    ovr_en = '0;

    // Asynchronous reset during LOAD of channel 1
    clear_logs();
    t = rand_taps();
    shift_taps(t);
    pulse_stb();
    wait_load(1);
    rst_n = 1'b0;
    #1;
    chk("arst_load", 64'(load), 64'd0);
    chk("arst_en_vtc", 64'(en_vtc), 64'hF);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_cntvaluein", 64'(cntvaluein), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < CH; k++) model_rb[k] = '0;
    @(negedge clk);
    chk("arst_idle_busy", 64'(busy), 64'd0);
    full_run(rand_taps());

    chk("single_channel_active", 64'(multi_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
